// File: rtl/switch_pkg.sv
// Shared types for the 3-port switch: destination encoding, ingress FSM states
// and the routability test applied to every incoming word.
package switch_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        DEST_NONE = 2'b00,
        DEST_P1   = 2'b01,
        DEST_P2   = 2'b10,
        DEST_P3   = 2'b11
    } dest_t;

    typedef enum logic {
        ING_EMPTY = 1'b0,
        ING_HOLD  = 1'b1
    } ingress_state_t;

    // Destination 00 has no output port behind it.
    function automatic logic dest_valid(input logic [1:0] dest);
        return dest_t'(dest) != DEST_NONE;
    endfunction

endpackage

// File: rtl/ingress_writer_if.sv
// Port-side word stream plus the input-FIFO write side of one ingress port.
interface ingress_writer_if
    import switch_pkg::*;
#(
    parameter int DATA_W = switch_pkg::DATA_W
) ();

    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              fifo_full;
    logic [DATA_W-1:0] fifo_data;
    logic              fifo_wrreq;

    modport master (
        output in_data, in_valid, fifo_full,
        input  in_ready, fifo_data, fifo_wrreq
    );

    modport slave (
        input  in_data, in_valid, fifo_full,
        output in_ready, fifo_data, fifo_wrreq
    );

endinterface

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/ingress_writer.sv
// One-word ingress stage: filters unroutable words, forwards the rest into the
// port's input FIFO and gives up on a word that stays blocked by fifo_full.
module ingress_writer
    import switch_pkg::*;
#(
    parameter int DATA_W    = switch_pkg::DATA_W,
    parameter int CNT_W     = 16,
    parameter int STALL_MAX = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    ingress_writer_if.slave  bus,
    output logic [CNT_W-1:0] accept_cnt,
    output logic [CNT_W-1:0] drop_cnt,
    output logic [CNT_W-1:0] timeout_cnt,
    output logic             stalled
);

    localparam int SW = (STALL_MAX > 1) ? $clog2(STALL_MAX) : 1;
    localparam logic [SW-1:0] STALL_LAST = SW'((STALL_MAX > 0) ? (STALL_MAX - 1) : 0);
    localparam logic TIMEOUT_ON = (STALL_MAX != 0);

    ingress_state_t    state;
    logic [DATA_W-1:0] hold_q;
    logic [SW-1:0]     stall_cnt;

    logic capture;
    logic route_ok;
    logic load;
    logic write;
    logic timeout;

    assign bus.in_ready   = (state == ING_EMPTY) || !bus.fifo_full;
    assign capture        = bus.in_valid && bus.in_ready;
    assign route_ok       = dest_valid(bus.in_data[1:0]);
    assign load           = capture && route_ok;
    assign write          = (state == ING_HOLD) && !bus.fifo_full;
    assign stalled        = (state == ING_HOLD) && bus.fifo_full;
    assign timeout        = stalled && TIMEOUT_ON && (stall_cnt == STALL_LAST);
    assign bus.fifo_wrreq = write;
    assign bus.fifo_data  = hold_q;

    // A load can only happen in HOLD when the held word is written on the same
    // edge, so taking the new word always wins over going back to EMPTY.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ING_EMPTY;
            hold_q    <= '0;
            stall_cnt <= '0;
        end else if (load) begin
            state     <= ING_HOLD;
            hold_q    <= bus.in_data;
            stall_cnt <= '0;
        end else if (write || timeout) begin
            state     <= ING_EMPTY;
            stall_cnt <= '0;
        end else if (stalled && TIMEOUT_ON) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    sat_counter #(.W(CNT_W)) u_accept_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (write),
        .count   (accept_cnt)
    );

    sat_counter #(.W(CNT_W)) u_drop_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (capture && !route_ok),
        .count   (drop_cnt)
    );

    sat_counter #(.W(CNT_W)) u_timeout_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (timeout),
        .count   (timeout_cnt)
    );

endmodule

// File: tb/tb_ingress_writer.sv
// Two ingress_writer instances (wide counters / long timeout, and 2-bit counters /
// 4-cycle timeout) driven by directed and random word streams against a word-level model.
module tb_ingress_writer;

    localparam int SRC_MAX = 1024;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    ingress_writer_if #(.DATA_W(8)) busA ();
    ingress_writer_if #(.DATA_W(8)) busB ();

    logic [15:0] accA, dropA, tmoA;
    logic [1:0]  accB, dropB, tmoB;
    logic        stallA, stallB;

    ingress_writer #(.DATA_W(8), .CNT_W(16), .STALL_MAX(64)) dutA (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (busA),
        .accept_cnt  (accA),
        .drop_cnt    (dropA),
        .timeout_cnt (tmoA),
        .stalled     (stallA)
    );

    ingress_writer #(.DATA_W(8), .CNT_W(2), .STALL_MAX(4)) dutB (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (busB),
        .accept_cnt  (accB),
        .drop_cnt    (dropB),
        .timeout_cnt (tmoB),
        .stalled     (stallB)
    );

    logic       drvValid [2];
    logic [7:0] drvData  [2];
    logic       drvFull  [2];

    assign busA.in_valid  = drvValid[0];
    assign busA.in_data   = drvData[0];
    assign busA.fifo_full = drvFull[0];
    assign busB.in_valid  = drvValid[1];
    assign busB.in_data   = drvData[1];
    assign busB.fifo_full = drvFull[1];

    int compared = 0;
    int mismatched = 0;

    // Words each port still has to offer, consumed in order on a handshake.
    logic [7:0] src [2][SRC_MAX];
    int         srcHead [2];
    int         srcTail [2];
    bit         presenting [2];

    // Reference model: which word is waiting for the FIFO and for how long.
    bit         held  [2];
    logic [7:0] hword [2];
    int         waitc [2];
    int         accM  [2];
    int         dropM [2];
    int         tmoM  [2];
    bit         pReady [2];
    bit         pWr    [2];
    bit         pStall [2];

    logic [7:0] expQ0 [$];
    logic [7:0] expQ1 [$];

    bit fullMode = 1'b0;
    bit fullVal  = 1'b0;
    bit gapMode  = 1'b0;

    function automatic int stallMaxOf(input int k);
        return (k == 0) ? 64 : 4;
    endfunction

    function automatic int cntMaxOf(input int k);
        return (k == 0) ? 65535 : 3;
    endfunction

    task automatic checkVal(input string name, input int actual, input int expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic pushWord(input int k, input logic [7:0] w);
        src[k][srcTail[k]] = w;
        srcTail[k]++;
    endtask

    task automatic clearModel();
        for (int k = 0; k < 2; k++) begin
            held[k]       = 1'b0;
            waitc[k]      = 0;
            accM[k]       = 0;
            dropM[k]      = 0;
            tmoM[k]       = 0;
            presenting[k] = 1'b0;
            pReady[k]     = 1'b1;
            pWr[k]        = 1'b0;
            pStall[k]     = 1'b0;
        end
    endtask

    task automatic applyStimulus();
        for (int k = 0; k < 2; k++) begin
            if (!presenting[k] && (srcHead[k] < srcTail[k]) &&
                !(gapMode && ($urandom_range(0, 3) == 0)))
                presenting[k] = 1'b1;
            drvValid[k] = presenting[k];
            drvData[k]  = presenting[k] ? src[k][srcHead[k]] : 8'($urandom);
            drvFull[k]  = fullMode ? ($urandom_range(0, 2) == 0) : fullVal;
            pReady[k]   = !held[k] || !drvFull[k];
            pWr[k]      = held[k] && !drvFull[k];
            pStall[k]   = held[k] && drvFull[k];
        end
    endtask

    task automatic checkDut(input string tag, input int k, input logic rdy, input logic wr,
                            input logic st, input int acc, input int drp, input int tmo);
        checkVal({tag, ".in_ready"},    int'(rdy), int'(pReady[k]));
        checkVal({tag, ".fifo_wrreq"},  int'(wr),  int'(pWr[k]));
        checkVal({tag, ".stalled"},     int'(st),  int'(pStall[k]));
        checkVal({tag, ".accept_cnt"},  acc, accM[k]);
        checkVal({tag, ".drop_cnt"},    drp, dropM[k]);
        checkVal({tag, ".timeout_cnt"}, tmo, tmoM[k]);
    endtask

    task automatic checkOutput();
        checkDut("A", 0, busA.in_ready, busA.fifo_wrreq, stallA, int'(accA), int'(dropA), int'(tmoA));
        checkDut("B", 1, busB.in_ready, busB.fifo_wrreq, stallB, int'(accB), int'(dropB), int'(tmoB));
    endtask

    // Advance the model across the coming rising edge.
    task automatic commitModel();
        bit xfer;
        bit tmo;
        for (int k = 0; k < 2; k++) begin
            xfer = drvValid[k] && pReady[k];
            tmo  = pStall[k] && (stallMaxOf(k) != 0) && (waitc[k] == stallMaxOf(k) - 1);
            if (pWr[k]) begin
                if (k == 0) expQ0.push_back(hword[k]);
                else        expQ1.push_back(hword[k]);
                if (accM[k] < cntMaxOf(k)) accM[k]++;
            end
            if (tmo && (tmoM[k] < cntMaxOf(k))) tmoM[k]++;
            if (xfer) begin
                srcHead[k]++;
                presenting[k] = 1'b0;
                if ((drvData[k] & 8'h03) == 8'h00 && dropM[k] < cntMaxOf(k)) dropM[k]++;
            end
            if (xfer && ((drvData[k] & 8'h03) != 8'h00)) begin
                held[k]  = 1'b1;
                hword[k] = drvData[k];
                waitc[k] = 0;
            end else if (pWr[k] || tmo) begin
                held[k]  = 1'b0;
                waitc[k] = 0;
            end else if (pStall[k]) begin
                waitc[k]++;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        reset_n = 1'b1;
        applyStimulus();
        #1;
        checkOutput();
        commitModel();
    endtask

    task automatic doReset(input int cycles);
        for (int n = 0; n < cycles; n++) begin
            @(negedge clk);
            reset_n = 1'b0;
            for (int k = 0; k < 2; k++) begin
                drvValid[k] = 1'b0;
                drvFull[k]  = 1'b0;
            end
            clearModel();
            #1;
            checkOutput();
        end
    endtask

    task automatic runTicks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pushBoth(input logic [7:0] w);
        pushWord(0, w);
        pushWord(1, w);
    endtask

    // Scoreboard side: every observed FIFO write must match the oldest expected word.
    always begin
        @(negedge clk);
        #2;
        if (busA.fifo_wrreq === 1'b1) begin
            if (expQ0.size() == 0) begin
                checkVal("A.unexpected_write", int'(busA.fifo_data), -1);
            end else begin
                checkVal("A.fifo_data", int'(busA.fifo_data), int'(expQ0.pop_front()));
            end
        end
        if (busB.fifo_wrreq === 1'b1) begin
            if (expQ1.size() == 0) begin
                checkVal("B.unexpected_write", int'(busB.fifo_data), -1);
            end else begin
                checkVal("B.fifo_data", int'(busB.fifo_data), int'(expQ1.pop_front()));
            end
        end
    end

    initial begin
        int budget;
        for (int k = 0; k < 2; k++) begin
            srcHead[k]  = 0;
            srcTail[k]  = 0;
            drvValid[k] = 1'b0;
            drvData[k]  = 8'h00;
            drvFull[k]  = 1'b0;
            hword[k]    = 8'h00;
        end
        clearModel();
        doReset(2);

        // Back-to-back stream with room in the FIFO.
        pushBoth(8'h05); pushBoth(8'h0A); pushBoth(8'h0F);
        runTicks(8);
        checkVal("stream.accA", int'(accA), 3);

        doReset(1);
        pushBoth(8'h04); pushBoth(8'h11);
        runTicks(6);
        checkVal("drop.dropA", int'(dropA), 1);
        checkVal("drop.accA", int'(accA), 1);

        // Long stall: A survives 10 full cycles, B times out after 4.
        doReset(1);
        pushBoth(8'h02);
        tick();
        fullVal = 1'b1;
        runTicks(10);
        fullVal = 1'b0;
        runTicks(3);
        checkVal("stall.accA", int'(accA), 1);
        checkVal("stall.tmoA", int'(tmoA), 0);
        checkVal("stall.accB", int'(accB), 0);
        checkVal("stall.tmoB", int'(tmoB), 1);

        // Reset while a word is held: that word must never reach the FIFO.
        doReset(1);
        pushBoth(8'h01);
        tick();
        fullVal = 1'b1;
        runTicks(2);
        doReset(1);
        fullVal = 1'b0;
        runTicks(5);
        checkVal("rst.accA", int'(accA), 0);

        doReset(1);
        pushBoth(8'h00); pushBoth(8'h04); pushBoth(8'h08); pushBoth(8'hFC); pushBoth(8'h10);
        runTicks(8);
        checkVal("sat.dropA", int'(dropA), 5);
        checkVal("sat.dropB", int'(dropB), 3);

        // Random words, gaps and FIFO back-pressure on each port independently.
        doReset(1);
        fullMode = 1'b1;
        gapMode  = 1'b1;
        for (int i = 0; i < 400; i++) begin
            pushWord(0, 8'($urandom));
            pushWord(1, 8'($urandom));
        end
        budget = 0;
        while (((srcHead[0] < srcTail[0]) || (srcHead[1] < srcTail[1])) && budget < 4000) begin
            tick();
            budget++;
        end
        checkVal("random.budget_left", int'(budget < 4000), 1);
        fullMode = 1'b0;
        gapMode  = 1'b0;
        runTicks(5);
        checkVal("random.expQ0_empty", expQ0.size(), 0);
        checkVal("random.expQ1_empty", expQ1.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/ingress_writer.md
Name: ingress_writer

Overview:
- Per-port ingress block of the 3-port switch; instantiated once per input port.
- Accepts the port's incoming 8-bit word stream over a valid/ready handshake and writes each word into that port's input FIFO via fifo_wrreq, honouring fifo_full.
- That FIFO is the one the crossbar scheduler later reads.
- Validates the destination field, data[1:0]: 01/10/11 select output ports 1/2/3.
  - Words with destination 00 are unroutable and are dropped at ingress.
  - A held word blocked too long by a full FIFO is discarded (head-of-line timeout).
- Saturating statistics counters are exported.

Parameters:
- DATA_W, 8: word width; bits [1:0] are the destination field.
- CNT_W, 16: width of each statistics counter.
- STALL_MAX, 64: cycles a held word may wait on fifo_full before it is discarded; 0 disables the timeout.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- in_data  in  DATA_W  incoming word from the port
- in_valid  in  1  in_data valid
- in_ready  out  1  block can accept in_data this cycle
- fifo_full  in  1  input FIFO full flag
- fifo_data  out  DATA_W  word presented to the FIFO
- fifo_wrreq  out  1  FIFO write strobe, sampled by the FIFO on the same edge as fifo_data
- accept_cnt  out  CNT_W  words written to the FIFO
- drop_cnt  out  CNT_W  words dropped for destination 00
- timeout_cnt  out  CNT_W  words discarded by the stall timeout
- stalled  out  1  a word is held and fifo_full is high

Behaviour:
- Reset (reset_n low, async): state EMPTY, hold register 0, stall_cnt 0, all counters 0. Outputs: fifo_wrreq 0, fifo_data 0, stalled 0, in_ready 1 (combinational from EMPTY).
- Handshake: a transfer occurs on a rising edge where in_valid && in_ready. in_valid must stay high with stable in_data until accepted; the block does not check this.
- FSM states: EMPTY (no word held), HOLD (one word held).
- in_ready = (state==EMPTY) || !fifo_full. This gives full throughput, one word per cycle, while the FIFO has room.
- Transfer with in_data[1:0]==00:
  - Word discarded; drop_cnt += 1.
  - Hold register and state unchanged by the capture itself; a concurrent write of the held word still completes.
- Transfer with a valid destination: word loaded into the hold register; state becomes HOLD.
- fifo_wrreq = (state==HOLD) && !fifo_full, combinational; fifo_data = hold register.
- On an edge with fifo_wrreq high:
  - accept_cnt += 1.
  - If a valid new word is captured on the same edge, stay in HOLD with the new word; otherwise go to EMPTY.
- Ingress latency: a word captured at edge N is written at edge N+1 if fifo_full is low in that cycle.
- Stall timeout:
  - In HOLD with fifo_full high, stall_cnt increments each edge.
  - stall_cnt resets to 0 on any write, any discard, or entry to EMPTY.
  - When STALL_MAX != 0 and stall_cnt == STALL_MAX-1 on a still-stalled edge: word discarded, timeout_cnt += 1, state becomes EMPTY.
  - No capture can coincide with the discard, because in_ready is 0 while stalled.
- stalled = (state==HOLD) && fifo_full.
- All counters saturate at all-ones; they never wrap.
- Simultaneous events on one edge (write + new valid capture, write + drop) are each applied. A counter increments at most once per edge.
- fifo_full toggling mid-hold: a write occurs on the first edge it is low; stall_cnt restarts from 0.
- reset_n asserted mid-operation: the held word is lost, counters clear, and nothing is written to the FIFO after assertion.

Decomposition:
- Shared package switch_pkg:
  - dest_t enum: DEST_NONE=2'b00, DEST_P1=01, DEST_P2=10, DEST_P3=11.
  - DATA_W default.
  - ingress FSM state typedef.
  - a function returning whether a word's destination is valid.
- Natural sub-module: sat_counter, a parameterised saturating counter with inc input. It is instantiated three times for the statistics; stall_cnt stays inline.

Test Plan:
- Reset then stream 0x05,0x0A,0x0F with in_valid held and fifo_full=0:
  - fifo_wrreq high for 3 consecutive cycles starting one cycle after the first accept;
  - fifo_data 0x05,0x0A,0x0F;
  - accept_cnt=3.
- Stream 0x04,0x11 with fifo_full=0:
  - 0x04 is never written, drop_cnt=1;
  - 0x11 written one cycle after its accept, accept_cnt=1.
- Capture 0x02, hold fifo_full=1 for 10 cycles, STALL_MAX=64:
  - stalled=1 and in_ready=0 for 10 cycles;
  - on release, 0x02 written on the first edge, accept_cnt=1, timeout_cnt=0.
- STALL_MAX=4, capture 0x03, hold fifo_full=1 indefinitely:
  - word discarded after 4 stalled edges, timeout_cnt=1, state EMPTY, in_ready=1, fifo_wrreq never asserted.
- Capture 0x01, assert reset_n low mid-hold for one cycle:
  - all counters 0, fifo_wrreq=0, in_ready=1 immediately;
  - 0x01 is never written.
- CNT_W=2, send 5 words with destination 00:
  - drop_cnt saturates at 3 and stays at 3.
